rt_subsystem: RTL and testbench

- Compact real-time subsystem shell: one word-addressed slave port feeding a control/status register bank, scratch RAM, GPIO, an optional UART transmitter and a 64-source interrupt pending/enable/priority unit.
- Sits between the SoC interconnect (or debug-access bridge) and the RT core's interrupt input.
- Exposes an end-of-computation (EOC) flag and exit code that the test harness polls.

---
 rtl/rt_subsystem.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_rt_subsystem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rt_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : rt_subsystem
// Description : Real-time subsystem shell. A single word-addressed slave port
//               fronts a CSR bank (CTRL/EOC, GPIO, UART, IRQ enable/pending)
//               and a scratch RAM. A 64-source level-interrupt unit with
//               fixed lowest-index priority drives the RT core's irq input.
// Ports       : clk_i/rst_i          clock, synchronous active-high reset
//               slv_*                request/grant/response slave port
//               gpio_input_i/_output_o  GPIO
//               uart_rx_i/uart_tx_o  UART (rx reserved, tx 8N1)
//               intr_src_i, irq_*    interrupt sources and core handshake
//               eoc_o/exit_code_o    end-of-computation flag and exit code
// Options     : RT_SS_UART_EN - when defined, the UART transmitter is built;
//               otherwise uart_tx_o idles high and UART registers read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rt_subsystem #(
    parameter int IrqNr    = 64,
    parameter int GpioW    = 8,
    parameter int RamWords = 256,
    parameter int AddrW    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             slv_req_i,
    input  logic             slv_we_i,
    input  logic [AddrW-1:0] slv_addr_i,
    input  logic [3:0]       slv_be_i,
    input  logic [31:0]      slv_wdata_i,
    output logic             slv_gnt_o,
    output logic             slv_rvalid_o,
    output logic [31:0]      slv_rdata_o,
    output logic             slv_err_o,
    input  logic [GpioW-1:0] gpio_input_i,
    output logic [GpioW-1:0] gpio_output_o,
    input  logic             uart_rx_i,
    output logic             uart_tx_o,
    input  logic [IrqNr-1:0] intr_src_i,
    output logic             irq_valid_o,
    output logic [5:0]       irq_id_o,
    input  logic             irq_ack_i,
    output logic             eoc_o,
    output logic [30:0]      exit_code_o
);
    localparam int          c_RAM_AW   = (RamWords > 1) ? $clog2(RamWords) : 1;
    // Pending/enable bits above IrqNr are forced to zero through this mask.
    localparam logic [63:0] c_IRQ_MASK = (IrqNr >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << IrqNr) - 64'd1);
    localparam logic [31:0] c_A_CTRL     = 32'h000;
    localparam logic [31:0] c_A_GPIO_OUT = 32'h004;
    localparam logic [31:0] c_A_GPIO_IN  = 32'h008;
    localparam logic [31:0] c_A_UART_TX  = 32'h00C;
    localparam logic [31:0] c_A_UART_DIV = 32'h010;
    localparam logic [31:0] c_A_EN_LO    = 32'h020;
    localparam logic [31:0] c_A_EN_HI    = 32'h024;
    localparam logic [31:0] c_A_PEND_LO  = 32'h028;
    localparam logic [31:0] c_A_PEND_HI  = 32'h02C;
    localparam logic [31:0] c_RAM_BASE   = 32'h400;
    localparam logic [31:0] c_RAM_END    = 32'h400 + 32'(4 * RamWords);

    // Registers
    logic             rvalid_q, err_q, ram_rd_q, eoc_q;
    logic [31:0]      rdata_q, ram_rdata_q;
    logic [30:0]      exit_code_q;
    logic [GpioW-1:0] gpio_out_q, gpio_in_q;
    logic [63:0]      en_q, pend_q, pend_d;
    logic [31:0]      ram_q [RamWords];

    // Decode results
    logic [31:0]         w_off, w_ram_off, w_rd_data, w_be_mask, w_gpio_merge;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic w_wr, w_rd, w_any_be, w_err, w_ram_sel;
    logic w_wr_ctrl, w_wr_gpio, w_wr_utx, w_wr_udiv;
    logic w_wr_en_lo, w_wr_en_hi, w_clr_lo, w_clr_hi;
    logic        w_uart_busy;
    logic [15:0] w_uart_div;

    // Interrupt logic
    logic [63:0] w_active, w_clr, w_ack_clr, w_src64;
    logic [5:0]  w_irq_id;

    assign w_off     = 32'({slv_addr_i[AddrW-1:2], 2'b00});
    assign w_ram_off = w_off - c_RAM_BASE;
    assign w_ram_idx = w_ram_off[c_RAM_AW+1:2];
    assign w_wr      = slv_req_i & slv_we_i;
    assign w_rd      = slv_req_i & ~slv_we_i;
    assign w_any_be  = |slv_be_i;
    assign w_be_mask = {{8{slv_be_i[3]}}, {8{slv_be_i[2]}}, {8{slv_be_i[1]}}, {8{slv_be_i[0]}}};
    assign w_gpio_merge = (32'(gpio_out_q) & ~w_be_mask) | (slv_wdata_i & w_be_mask);

    always_comb begin
        w_rd_data  = 32'd0;
        w_err      = 1'b0;
        w_ram_sel  = 1'b0;
        w_wr_ctrl  = 1'b0;
        w_wr_gpio  = 1'b0;
        w_wr_utx   = 1'b0;
        w_wr_udiv  = 1'b0;
        w_wr_en_lo = 1'b0;
        w_wr_en_hi = 1'b0;
        w_clr_lo   = 1'b0;
        w_clr_hi   = 1'b0;
        case (w_off)
            c_A_CTRL: begin
                w_rd_data = {exit_code_q, eoc_q};
                // Only a write carrying bit0=1 signals end of computation.
                w_wr_ctrl = w_wr & w_any_be & slv_wdata_i[0];
            end
            c_A_GPIO_OUT: begin
                w_rd_data = 32'(gpio_out_q);
                w_wr_gpio = w_wr;
            end
            c_A_GPIO_IN: begin
                w_rd_data = 32'(gpio_in_q);
                w_err     = slv_we_i;
            end
            c_A_UART_TX: begin
                w_rd_data = {31'd0, w_uart_busy};
                w_wr_utx  = w_wr & w_any_be;
            end
            c_A_UART_DIV: begin
                w_rd_data = {16'd0, w_uart_div};
                w_wr_udiv = w_wr;
            end
            c_A_EN_LO: begin
                w_rd_data  = en_q[31:0];
                w_wr_en_lo = w_wr & w_any_be;
            end
            c_A_EN_HI: begin
                w_rd_data  = en_q[63:32];
                w_wr_en_hi = w_wr & w_any_be;
            end
            c_A_PEND_LO: begin
                w_rd_data = pend_q[31:0];
                w_clr_lo  = w_wr & w_any_be;
            end
            c_A_PEND_HI: begin
                w_rd_data = pend_q[63:32];
                w_clr_hi  = w_wr & w_any_be;
            end
            default: begin
                if ((w_off >= c_RAM_BASE) && (w_off < c_RAM_END)) begin
                    w_ram_sel = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
        endcase
    end

    // Fixed priority: lowest pending-and-enabled index wins.
    assign w_active = pend_q & en_q;
    always_comb begin
        w_irq_id = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (w_active[i]) begin
                w_irq_id = 6'(i);
            end
        end
    end

    assign w_src64   = 64'(intr_src_i);
    assign w_clr     = {(w_clr_hi ? slv_wdata_i : 32'd0), (w_clr_lo ? slv_wdata_i : 32'd0)};
    assign w_ack_clr = (irq_ack_i && irq_valid_o) ? (64'd1 << w_irq_id) : 64'd0;
    // Sources are ORed in last so a live source always beats W1C or ack.
    assign pend_d    = ((pend_q & ~w_clr & ~w_ack_clr) | w_src64) & c_IRQ_MASK;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            ram_rd_q    <= 1'b0;
            rdata_q     <= 32'd0;
            eoc_q       <= 1'b0;
            exit_code_q <= 31'd0;
            gpio_out_q  <= '0;
            gpio_in_q   <= '0;
            en_q        <= 64'd0;
            pend_q      <= 64'd0;
        end else begin
            rvalid_q  <= slv_req_i;
            err_q     <= slv_req_i & w_err;
            ram_rd_q  <= w_rd & w_ram_sel;
            rdata_q   <= (w_rd && !w_err && !w_ram_sel) ? w_rd_data : 32'd0;
            gpio_in_q <= gpio_input_i;
            if (w_wr_ctrl) begin
                eoc_q       <= 1'b1;
                exit_code_q <= slv_wdata_i[31:1];
            end
            if (w_wr_gpio) begin
                gpio_out_q <= w_gpio_merge[GpioW-1:0];
            end
            if (w_wr_en_lo) begin
                en_q[31:0] <= slv_wdata_i & c_IRQ_MASK[31:0];
            end
            if (w_wr_en_hi) begin
                en_q[63:32] <= slv_wdata_i & c_IRQ_MASK[63:32];
            end
            pend_q <= pend_d;
        end
    end

    // Scratch RAM: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (w_ram_sel && w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (slv_be_i[b]) begin
                    ram_q[w_ram_idx][8*b +: 8] <= slv_wdata_i[8*b +: 8];
                end
            end
        end
        if (w_ram_sel && w_rd) begin
            ram_rdata_q <= ram_q[w_ram_idx];
        end
    end

`ifdef RT_SS_UART_EN
    typedef enum logic [0:0] {
        UART_IDLE = 1'b0,
        UART_BUSY = 1'b1
    } uart_state_e;

    uart_state_e uart_state_q;
    logic [15:0] uart_div_q, uart_cnt_q;
    logic [3:0]  uart_bitcnt_q;
    logic [9:0]  uart_sh_q;      // {stop, data[7:0], start}, shifted out LSB first

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uart_state_q  <= UART_IDLE;
            uart_div_q    <= 16'd0;
            uart_cnt_q    <= 16'd0;
            uart_bitcnt_q <= 4'd0;
            uart_sh_q     <= '1;
        end else begin
            if (w_wr_udiv && slv_be_i[0]) uart_div_q[7:0]  <= slv_wdata_i[7:0];
            if (w_wr_udiv && slv_be_i[1]) uart_div_q[15:8] <= slv_wdata_i[15:8];
            case (uart_state_q)
                UART_IDLE: begin
                    if (w_wr_utx) begin
                        uart_sh_q     <= {1'b1, slv_wdata_i[7:0], 1'b0};
                        uart_cnt_q    <= uart_div_q;
                        uart_bitcnt_q <= 4'd0;
                        uart_state_q  <= UART_BUSY;
                    end
                end
                UART_BUSY: begin
                    if (uart_cnt_q == 16'd0) begin
                        if (uart_bitcnt_q == 4'd9) begin
                            uart_sh_q    <= '1;
                            uart_state_q <= UART_IDLE;
                        end else begin
                            uart_sh_q     <= {1'b1, uart_sh_q[9:1]};
                            uart_bitcnt_q <= uart_bitcnt_q + 4'd1;
                            uart_cnt_q    <= uart_div_q;
                        end
                    end else begin
                        uart_cnt_q <= uart_cnt_q - 16'd1;
                    end
                end
                default: uart_state_q <= UART_IDLE;
            endcase
        end
    end

    assign w_uart_busy = (uart_state_q == UART_BUSY);
    assign w_uart_div  = uart_div_q;
    assign uart_tx_o   = uart_sh_q[0];
`else
    logic w_unused_uart;
    assign w_unused_uart = ^{w_wr_utx, w_wr_udiv};
    assign w_uart_busy   = 1'b0;
    assign w_uart_div    = 16'd0;
    assign uart_tx_o     = 1'b1;
`endif

    logic w_unused;
    assign w_unused = ^{uart_rx_i, slv_addr_i[1:0], w_gpio_merge, w_ram_off};

    assign slv_gnt_o     = slv_req_i;
    assign slv_rvalid_o  = rvalid_q;
    assign slv_err_o     = err_q;
    assign slv_rdata_o   = ram_rd_q ? ram_rdata_q : rdata_q;
    assign gpio_output_o = gpio_out_q;
    assign irq_valid_o   = |w_active;
    assign irq_id_o      = w_irq_id;
    assign eoc_o         = eoc_q;
    assign exit_code_o   = exit_code_q;

endmodule
`default_nettype wire

// File: tb/tb_rt_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : tb_rt_subsystem
// Description : Scoreboard bench for rt_subsystem. Accesses push their
//               expected {err, rdata} into a queue; a monitor pops and
//               compares on every slv_rvalid_o. Side-band outputs (EOC, IRQ,
//               GPIO, UART line) are checked directly after each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rt_subsystem;
    localparam int IRQ_NR = 64;
    localparam int GPIO_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req, we;
    logic [11:0]       addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt, rvalid, err;
    logic [31:0]       rdata;
    logic [GPIO_W-1:0] gpio_in, gpio_out;
    logic              uart_tx;
    logic [IRQ_NR-1:0] intr;
    logic              irq_valid, irq_ack;
    logic [5:0]        irq_id;
    logic              eoc;
    logic [30:0]       exit_code;

    always #5 clk = ~clk;

    rt_subsystem dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slv_req_i     (req),
        .slv_we_i      (we),
        .slv_addr_i    (addr),
        .slv_be_i      (be),
        .slv_wdata_i   (wdata),
        .slv_gnt_o     (gnt),
        .slv_rvalid_o  (rvalid),
        .slv_rdata_o   (rdata),
        .slv_err_o     (err),
        .gpio_input_i  (gpio_in),
        .gpio_output_o (gpio_out),
        .uart_rx_i     (1'b1),
        .uart_tx_o     (uart_tx),
        .intr_src_i    (intr),
        .irq_valid_o   (irq_valid),
        .irq_id_o      (irq_id),
        .irq_ack_i     (irq_ack),
        .eoc_o         (eoc),
        .exit_code_o   (exit_code)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; the request is accepted at the next
    // edge and the task returns 1 time unit after it.
    task automatic acc(input logic a_we, input logic [11:0] a_addr, input logic [3:0] a_be,
                       input logic [31:0] a_wd, input logic [31:0] e_rd, input logic e_err);
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        be    = a_be;
        wdata = a_wd;
        exp_q.push_back({e_err, e_rd});
        #1;
        chk("gnt", 64'(gnt), 64'd1);
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        wdata = 32'd0;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 expected no response at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rsp_err_rdata", 64'({err, rdata}), 64'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    logic [9:0] frame;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        gpio_in = 8'hC3; intr = '0; irq_ack = 1'b0;
        frame = {1'b1, 8'hA5, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_out", 64'(gpio_out), 64'd0);
        chk("rst_uart_tx", 64'(uart_tx), 64'd1);
        chk("rst_eoc", 64'(eoc), 64'd0);
        chk("rst_irq_valid", 64'(irq_valid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        acc(0, 12'h000, 4'h0, 32'd0, 32'd0, 1'b0);

        // RAM with partial byte enables, last word, and first address past RAM
        acc(1, 12'h400, 4'hF, 32'd0,        32'd0,        1'b0);
        acc(1, 12'h400, 4'h3, 32'hCAFEF00D, 32'd0,        1'b0);
        acc(0, 12'h400, 4'h0, 32'd0,        32'h0000F00D, 1'b0);
        acc(1, 12'h7FC, 4'hF, 32'h12345678, 32'd0,        1'b0);
        acc(0, 12'h7FC, 4'h0, 32'd0,        32'h12345678, 1'b0);
        acc(0, 12'h800, 4'h0, 32'd0,        32'd0,        1'b1);

        // CTRL / EOC
        acc(1, 12'h000, 4'hF, 32'h15, 32'd0, 1'b0);
        chk("eoc_set", 64'(eoc), 64'd1);
        chk("exit_code", 64'(exit_code), 64'h0A);
        acc(1, 12'h000, 4'hF, 32'h0, 32'd0, 1'b0);
        chk("eoc_sticky", 64'(eoc), 64'd1);
        chk("exit_code_kept", 64'(exit_code), 64'h0A);
        acc(0, 12'h000, 4'h0, 32'd0, 32'h15, 1'b0);

        // Decode errors
        acc(0, 12'h100, 4'h0, 32'd0,  32'd0, 1'b1);
        acc(1, 12'h008, 4'hF, 32'h55, 32'd0, 1'b1);

        // GPIO
        acc(1, 12'h004, 4'h1, 32'hFFFFFF5A, 32'd0, 1'b0);
        chk("gpio_out", 64'(gpio_out), 64'h5A);
        acc(0, 12'h004, 4'h0, 32'd0, 32'h5A, 1'b0);
        acc(0, 12'h008, 4'h0, 32'd0, 32'hC3, 1'b0);

        // Interrupts: priority and ack
        acc(1, 12'h020, 4'hF, 32'h28, 32'd0, 1'b0);
        intr[3] = 1'b1; intr[5] = 1'b1;
        @(posedge clk); #1;
        intr = '0;
        chk("irq_valid_35", 64'(irq_valid), 64'd1);
        chk("irq_id_3", 64'(irq_id), 64'd3);
        acc(0, 12'h028, 4'h0, 32'd0, 32'h28, 1'b0);
        irq_ack = 1'b1; @(posedge clk); #1; irq_ack = 1'b0;
        chk("irq_valid_5", 64'(irq_valid), 64'd1);
        chk("irq_id_5", 64'(irq_id), 64'd5);
        irq_ack = 1'b1; @(posedge clk); #1; irq_ack = 1'b0;
        chk("irq_valid_none", 64'(irq_valid), 64'd0);
        chk("irq_id_none", 64'(irq_id), 64'd0);

        // Set beats W1C in the same cycle
        intr[3] = 1'b1;
        acc(1, 12'h028, 4'hF, 32'h8, 32'd0, 1'b0);
        intr = '0;
        acc(0, 12'h028, 4'h0, 32'd0, 32'h8, 1'b0);
        acc(1, 12'h028, 4'hF, 32'h8, 32'd0, 1'b0);
        acc(0, 12'h028, 4'h0, 32'd0, 32'd0, 1'b0);
        chk("irq_valid_w1c", 64'(irq_valid), 64'd0);

        // Upper-half source with enable gating
        intr[40] = 1'b1;
        @(posedge clk); #1;
        intr = '0;
        chk("irq40_masked", 64'(irq_valid), 64'd0);
        acc(0, 12'h02C, 4'h0, 32'd0, 32'h100, 1'b0);
        acc(1, 12'h024, 4'hF, 32'h100, 32'd0, 1'b0);
        chk("irq40_valid", 64'(irq_valid), 64'd1);
        chk("irq40_id", 64'(irq_id), 64'd40);
        acc(1, 12'h02C, 4'hF, 32'h100, 32'd0, 1'b0);
        chk("irq40_cleared", 64'(irq_valid), 64'd0);
        acc(0, 12'h02C, 4'h0, 32'd0, 32'd0,   1'b0);
        acc(0, 12'h024, 4'h0, 32'd0, 32'h100, 1'b0);

`ifdef RT_SS_UART_EN
        acc(1, 12'h010, 4'h1, 32'hFFFFFF03, 32'd0, 1'b0);
        acc(0, 12'h010, 4'h0, 32'd0, 32'h3, 1'b0);
        acc(1, 12'h00C, 4'hF, 32'hA5, 32'd0, 1'b0);
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    chk("uart_tx_bit", 64'(uart_tx), 64'(frame[k/4]));
                end
            end
            begin
                acc(1, 12'h00C, 4'hF, 32'hFF, 32'd0, 1'b0);   // dropped while busy
                repeat (38) @(posedge clk);
                #1;
                acc(0, 12'h00C, 4'h0, 32'd0, 32'h1, 1'b0);    // last busy cycle
                acc(0, 12'h00C, 4'h0, 32'd0, 32'h0, 1'b0);    // busy cleared
            end
        join
        chk("uart_idle", 64'(uart_tx), 64'd1);
`else
        acc(1, 12'h010, 4'hF, 32'h3,  32'd0, 1'b0);
        acc(0, 12'h010, 4'h0, 32'd0,  32'd0, 1'b0);
        acc(1, 12'h00C, 4'hF, 32'hA5, 32'd0, 1'b0);
        acc(0, 12'h00C, 4'h0, 32'd0,  32'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("uart_tx_tied", 64'(uart_tx), 64'd1);
        end
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
